// File: rtl/mac_fault_pkg.sv
// Shared definitions for the multi-cycle faulty MAC slice: bridge-type
// encodings, the control FSM state type and the stuck-at merge helper.
package mac_fault_pkg;

    // Bridge behaviour selected by bridge_type
    localparam logic [1:0] BR_WAND    = 2'b00;  // both nets take a&b
    localparam logic [1:0] BR_WOR     = 2'b01;  // both nets take a|b
    localparam logic [1:0] BR_DOM     = 2'b10;  // net i+1 follows net i
    localparam logic [1:0] BR_DOM_AND = 2'b11;  // net i+1 takes a&b

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Widest weight the stuck-at helper handles; callers zero-extend.
    localparam int SAF_W_MAX = 16;

    // Bits selected by m are forced to v, the rest keep w.
    function automatic logic [SAF_W_MAX-1:0] saf_apply(
        input logic [SAF_W_MAX-1:0] w,
        input logic [SAF_W_MAX-1:0] v,
        input logic [SAF_W_MAX-1:0] m
    );
        return (w & ~m) | (v & m);
    endfunction

endpackage

// File: rtl/mac_fault_inject.sv
// Combinational fault injection over the registered snapshot.
// Stuck-at faults always present; bridging faults only when
// MAC_BRIDGE_FAULT_EN is defined, otherwise inputs pass through.
module mac_fault_inject
    import mac_fault_pkg::*;
#(
    parameter int N_IN   = 256,
    parameter int W_BITS = 4,
    parameter int IDX_W  = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]        x_snap,
    input  logic [N_IN*W_BITS-1:0] w_snap,
    input  logic                   saf_en,
    input  logic [IDX_W-1:0]       saf_idx,
    input  logic [W_BITS-1:0]      saf_val,
    input  logic [W_BITS-1:0]      saf_mask,
    input  logic                   br_en,
    input  logic [N_IN-1:0]        br_mask,
    input  logic [1:0]             br_type,
    output logic [N_IN-1:0]        x_f,
    output logic [N_IN*W_BITS-1:0] w_f
);

    // Stuck-at: only the slot matching the index is modified; an index at
    // or beyond N_IN matches no slot and so injects nothing.
    always_comb begin
        w_f = w_snap;
        for (int k = 0; k < N_IN; k++) begin
            if (saf_en && (32'(saf_idx) == 32'(k))) begin
                w_f[k*W_BITS +: W_BITS] = W_BITS'(saf_apply(
                    SAF_W_MAX'(w_snap[k*W_BITS +: W_BITS]),
                    SAF_W_MAX'(saf_val),
                    SAF_W_MAX'(saf_mask)));
            end
        end
    end

`ifdef MAC_BRIDGE_FAULT_EN
    logic br_a;
    logic br_b;

    // Bridge pairs resolved low-to-high so a run of masked nets cascades.
    always_comb begin
        x_f  = x_snap;
        br_a = 1'b0;
        br_b = 1'b0;
        if (br_en) begin
            for (int i = 0; i < N_IN - 1; i++) begin
                if (br_mask[i] && br_mask[i+1]) begin
                    br_a = x_f[i];
                    br_b = x_f[i+1];
                    case (br_type)
                        BR_WAND: begin
                            x_f[i]   = br_a & br_b;
                            x_f[i+1] = br_a & br_b;
                        end
                        BR_WOR: begin
                            x_f[i]   = br_a | br_b;
                            x_f[i+1] = br_a | br_b;
                        end
                        BR_DOM:     x_f[i+1] = br_a;
                        default:    x_f[i+1] = br_a & br_b;
                    endcase
                end
            end
        end
    end
`else
    logic br_unused;

    // Bridging not built: inputs pass straight through.
    always_comb begin
        x_f       = x_snap;
        br_unused = br_en ^ (^br_mask) ^ (^br_type);
    end
`endif

endmodule

// File: rtl/mac_slice_faulty_seq.sv
// Multi-cycle faulty MAC slice. Snapshots a request on acceptance, runs
// N_IN/LANES accumulation beats over the fault-injected snapshot and
// presents a wrapped sum with a sticky overflow flag.
// Optional bridging faults: define MAC_BRIDGE_FAULT_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with its payload until that edge.
module mac_slice_faulty_seq
    import mac_fault_pkg::*;
#(
    parameter int N_IN   = 256,
    parameter int W_BITS = 4,
    parameter int LANES  = 32,
    parameter int SUM_W  = 16,
    parameter int IDX_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN-1:0]        in_array,
    input  logic [N_IN*W_BITS-1:0] weight_array,
    input  logic                   saf_enable,
    input  logic [IDX_W-1:0]       saf_index,
    input  logic [W_BITS-1:0]      saf_value,
    input  logic [W_BITS-1:0]      saf_mask,
    input  logic                   bridge_enable,
    input  logic [N_IN-1:0]        bridge_mask,
    input  logic [1:0]             bridge_type,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_W-1:0]       sum,
    output logic                   overflow
);

    localparam int BEATS  = N_IN / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = W_BITS + $clog2(LANES) + 1;
    localparam int ADD_W  = ((SUM_W > BEAT_W) ? SUM_W : BEAT_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                  state;
    logic [N_IN-1:0]         x_snap;
    logic [N_IN*W_BITS-1:0]  w_snap;
    logic                    saf_en_q;
    logic [IDX_W-1:0]        saf_idx_q;
    logic [W_BITS-1:0]       saf_val_q;
    logic [W_BITS-1:0]       saf_mask_q;
    logic                    br_en_q;
    logic [N_IN-1:0]         br_mask_q;
    logic [1:0]              br_type_q;

    logic [CNT_W-1:0]        beat_q;
    logic [SUM_W-1:0]        acc_q;
    logic                    acc_ovf_q;
    logic [SUM_W-1:0]        sum_q;
    logic                    ovf_q;
    logic                    out_valid_q;

    logic [N_IN-1:0]         x_f;
    logic [N_IN*W_BITS-1:0]  w_f;
    logic [BEAT_W-1:0]       beat_sum;
    logic [ADD_W-1:0]        add_full;
    logic [SUM_W-1:0]        acc_next;
    logic                    carry;
    logic                    accept;
    int                      lane_idx;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign overflow  = ovf_q;

    mac_fault_inject #(
        .N_IN   (N_IN),
        .W_BITS (W_BITS),
        .IDX_W  (IDX_W)
    ) u_inject (
        .x_snap   (x_snap),
        .w_snap   (w_snap),
        .saf_en   (saf_en_q),
        .saf_idx  (saf_idx_q),
        .saf_val  (saf_val_q),
        .saf_mask (saf_mask_q),
        .br_en    (br_en_q),
        .br_mask  (br_mask_q),
        .br_type  (br_type_q),
        .x_f      (x_f),
        .w_f      (w_f)
    );

    // Sum of the LANES products selected by the current beat.
    always_comb begin
        beat_sum = '0;
        lane_idx = 0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx = int'(beat_q) * LANES + l;
            if (x_f[lane_idx]) begin
                beat_sum = beat_sum + BEAT_W'(w_f[lane_idx*W_BITS +: W_BITS]);
            end
        end
    end

    // Wrapped accumulate; anything above SUM_W counts as a wrap.
    always_comb begin
        add_full = ADD_W'(acc_q) + ADD_W'(beat_sum);
        acc_next = add_full[SUM_W-1:0];
        carry    = |add_full[ADD_W-1:SUM_W];
    end

    // Request snapshot: data and fault controls captured only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_snap     <= '0;
            w_snap     <= '0;
            saf_en_q   <= 1'b0;
            saf_idx_q  <= '0;
            saf_val_q  <= '0;
            saf_mask_q <= '0;
            br_en_q    <= 1'b0;
            br_mask_q  <= '0;
            br_type_q  <= '0;
        end else if (accept) begin
            x_snap     <= in_array;
            w_snap     <= weight_array;
            saf_en_q   <= saf_enable;
            saf_idx_q  <= saf_index;
            saf_val_q  <= saf_value;
            saf_mask_q <= saf_mask;
            br_en_q    <= bridge_enable;
            br_mask_q  <= bridge_mask;
            br_type_q  <= bridge_type;
        end
    end

    // Control FSM with accumulator, beat counter and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            beat_q      <= '0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        beat_q    <= '0;
                        acc_q     <= '0;
                        acc_ovf_q <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q     <= acc_next;
                    acc_ovf_q <= acc_ovf_q | carry;
                    if (beat_q == LAST_BEAT) begin
                        sum_q       <= acc_next;
                        ovf_q       <= acc_ovf_q | carry;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        beat_q <= beat_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            beat_q    <= '0;
                            acc_q     <= '0;
                            acc_ovf_q <= 1'b0;
                            state     <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_slice_faulty_seq.sv
// Bench for mac_slice_faulty_seq: directed transactions on a default
// instance and an SUM_W=8 instance driven in lockstep.
module tb_mac_slice_faulty_seq;

    localparam int N  = 256;
    localparam int WB = 4;
    localparam int L  = 32;
    localparam int B  = N / L;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_ready8;
    logic [N-1:0]     in_array;
    logic [N*WB-1:0]  weight_array;
    logic             saf_enable;
    logic [7:0]       saf_index;
    logic [WB-1:0]    saf_value;
    logic [WB-1:0]    saf_mask;
    logic             bridge_enable;
    logic [N-1:0]     bridge_mask;
    logic [1:0]       bridge_type;
    logic             out_valid;
    logic             out_valid8;
    logic             out_ready;
    logic [15:0]      sum;
    logic [7:0]       sum8;
    logic             overflow;
    logic             overflow8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    int          acc_cyc_q[$];
    bit          front_seen = 0;

    typedef struct {
        logic [N-1:0]    x;
        logic [N*WB-1:0] w;
        logic            saf_en;
        logic [7:0]      saf_idx;
        logic [WB-1:0]   saf_val;
        logic [WB-1:0]   saf_mask;
        logic            br_en;
        logic [N-1:0]    br_mask;
        logic [1:0]      br_type;
    } txn_t;

    mac_slice_faulty_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_array(in_array), .weight_array(weight_array),
        .saf_enable(saf_enable), .saf_index(saf_index), .saf_value(saf_value),
        .saf_mask(saf_mask), .bridge_enable(bridge_enable),
        .bridge_mask(bridge_mask), .bridge_type(bridge_type),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .overflow(overflow)
    );

    mac_slice_faulty_seq #(.SUM_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_array(in_array), .weight_array(weight_array),
        .saf_enable(saf_enable), .saf_index(saf_index), .saf_value(saf_value),
        .saf_mask(saf_mask), .bridge_enable(bridge_enable),
        .bridge_mask(bridge_mask), .bridge_type(bridge_type),
        .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
        .overflow(overflow8)
    );

    // Clock and cycle counter
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the faulty dot product as an unbounded integer.
    function automatic int model_total(input txn_t t);
        int wv[N];
        bit xv[N];
        int total;
        int si;
        bit a;
        bit b;
        total = 0;
        for (int k = 0; k < N; k++) begin
            wv[k] = int'(t.w[k*WB +: WB]);
            xv[k] = t.x[k];
        end
        si = int'(t.saf_idx);
        if (t.saf_en && si < N) begin
            for (int bt = 0; bt < WB; bt++) begin
                if (t.saf_mask[bt]) begin
                    if (t.saf_val[bt]) wv[si] = wv[si] | (1 << bt);
                    else               wv[si] = wv[si] & ~(1 << bt);
                end
            end
        end
`ifdef MAC_BRIDGE_FAULT_EN
        if (t.br_en) begin
            for (int i = 0; i < N - 1; i++) begin
                if (t.br_mask[i] && t.br_mask[i+1]) begin
                    a = xv[i];
                    b = xv[i+1];
                    case (t.br_type)
                        2'b00: begin xv[i] = a & b; xv[i+1] = a & b; end
                        2'b01: begin xv[i] = a | b; xv[i+1] = a | b; end
                        2'b10: xv[i+1] = a;
                        default: xv[i+1] = a & b;
                    endcase
                end
            end
        end
`else
        a = 0;
        b = 0;
`endif
        for (int k = 0; k < N; k++) if (xv[k]) total += wv[k];
        return total;
    endfunction

    function automatic txn_t blank();
        txn_t t;
        t.x = '0; t.w = '0; t.saf_en = 0; t.saf_idx = '0; t.saf_val = '0;
        t.saf_mask = '0; t.br_en = 0; t.br_mask = '0; t.br_type = '0;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        in_array      = t.x;
        weight_array  = t.w;
        saf_enable    = t.saf_en;
        saf_index     = t.saf_idx;
        saf_value     = t.saf_val;
        saf_mask      = t.saf_mask;
        bridge_enable = t.br_en;
        bridge_mask   = t.br_mask;
        bridge_type   = t.br_type;
    endtask

    // Present a request and hold it until the edge that accepts it.
    task automatic send(input txn_t t, output int acc_c);
        bit done;
        done  = 0;
        acc_c = -1;
        drive(t);
        in_valid = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_c = cyc + 1;
                exp_q.push_back(32'(model_total(t)));
                acc_cyc_q.push_back(acc_c);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
    endtask

    // One transaction with literal expectations for model and DUT.
    task automatic run(input string name, input txn_t t, input int lit16,
                       input int lit8, input int lit_ovf8);
        int ac;
        chk({name, "_model"}, model_total(t) % 65536, lit16);
        send(t, ac);
        drain();
        chk({name, "_sum16"}, int'(sum), lit16);
        chk({name, "_ovf16"}, int'(overflow), 0);
        chk({name, "_sum8"}, int'(sum8), lit8);
        chk({name, "_ovf8"}, int'(overflow8), lit_ovf8);
    endtask

    // Scoreboard: every cycle a result is presented it must match the head.
    always @(negedge clk) begin
        if (!rst_n) begin
            front_seen = 0;
        end else begin
            chk("valid_pair", int'(out_valid8), int'(out_valid));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result actual=sum %0d required=no_result", sum);
                end else begin
                    chk("sum16", int'(sum), int'(exp_q[0] % 65536));
                    chk("ovf16", int'(overflow), int'(exp_q[0] >= 65536));
                    chk("sum8", int'(sum8), int'(exp_q[0] % 256));
                    chk("ovf8", int'(overflow8), int'(exp_q[0] >= 256));
                    if (!front_seen) begin
                        chk("latency", cyc, acc_cyc_q[0] + B);
                        front_seen = 1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_cyc_q.pop_front());
                        front_seen = 0;
                    end
                end
            end else if (exp_q.size() != 0 && cyc > acc_cyc_q[0] + B) begin
                checks++; errors++;
                $display("FAIL late_result actual=cycle %0d required=cycle %0d",
                         cyc, acc_cyc_q[0] + B);
                void'(exp_q.pop_front());
                void'(acc_cyc_q.pop_front());
                front_seen = 0;
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    txn_t t_ones, t_saf3, t_br, t_alt, t_s0, t_s255, t_saf_off;
    int   acc_a, acc_b;

    initial begin
        // Clock/reset block
        rst_n = 0; in_valid = 0; out_ready = 1;
        drive(blank());
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_sum8", int'(sum8), 0);
        @(posedge clk); #1;

        // Stimulus vectors
        t_ones = blank();
        t_ones.x = '1;
        t_ones.w = '1;

        t_saf3 = blank();
        t_saf3.x[3] = 1'b1;
        t_saf3.w[3*WB +: WB] = 4'h6;
        t_saf3.saf_en = 1; t_saf3.saf_idx = 8'd3;
        t_saf3.saf_val = 4'h9; t_saf3.saf_mask = 4'hC;

        t_saf_off = t_saf3;
        t_saf_off.saf_en = 0;

        t_br = blank();
        t_br.x[0] = 1'b1;
        for (int k = 0; k < N; k++) t_br.w[k*WB +: WB] = 4'h1;
        t_br.br_en = 1; t_br.br_mask[2:0] = 3'b111; t_br.br_type = 2'b10;

        t_alt = blank();
        for (int k = 0; k < N; k++) begin
            t_alt.x[k] = k[0];
            t_alt.w[k*WB +: WB] = 4'(k % 16);
        end

        t_s0 = t_ones;
        t_s0.saf_en = 1; t_s0.saf_idx = 8'd0; t_s0.saf_val = 4'h0; t_s0.saf_mask = 4'hF;
        t_s255 = t_s0;
        t_s255.saf_idx = 8'd255;

        // Directed transactions
        run("all_ones", t_ones, 3840, 0, 1);
        run("saf_idx3", t_saf3, 10, 10, 0);
        run("saf_disabled", t_saf_off, 6, 6, 0);
`ifdef MAC_BRIDGE_FAULT_EN
        run("bridge_dom", t_br, 3, 3, 0);
        t_br.br_type = 2'b00;
        run("bridge_wand", t_br, 0, 0, 0);
`else
        run("bridge_off", t_br, 1, 1, 0);
        t_br.br_type = 2'b00;
        run("bridge_off2", t_br, 1, 1, 0);
`endif
        run("saf_first", t_s0, 3825, 241, 1);
        run("saf_last", t_s255, 3825, 241, 1);

        // Result held while the consumer stalls
        out_ready = 0;
        chk("alt_model", model_total(t_alt), 1024);
        send(t_alt, acc_a);
        repeat (B + 6) @(posedge clk);
        #2;
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_sum", int'(sum), 1024);
        out_ready = 1;
        drain();

        // Back-to-back with in_valid pulses during RUN
        send(t_ones, acc_a);
        for (int i = 0; i < 3; i++) begin
            drive(t_saf3);
            in_valid = 1;
            @(negedge clk);
            chk("run_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 0;
        send(t_s0, acc_b);
        chk("b2b_spacing", acc_b - acc_a, B + 1);
        drain();
        chk("b2b_sum", int'(sum), 3825);

        // Reset mid-RUN aborts the transaction
        send(t_alt, acc_a);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        exp_q.delete();
        acc_cyc_q.delete();
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_sum", int'(sum), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_ovf8", int'(overflow8), 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (B + 3) @(posedge clk);
        #2;
        chk("post_rst_no_valid", int'(out_valid), 0);
        run("post_rst", t_saf3, 10, 10, 0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
